fwd_hazard_unit: RTL and testbench

Parametrised successor to the pipeline forwarding unit. Selects the EX-stage operand source from NSTAGE downstream pipeline registers. Detects load-use hazards against the ID stage. Tracks outstanding long-latency register writes (divide, uncached load) in a per-register scoreboard. Sits between ID/EX control and the EX operand muxes, and drives the ID stall and EX bubble.

---
 rtl/fwd_hazard_unit.sv | 134 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding select, load-use / scoreboard / long-latency hazard detection, stall/bubble drive.
// Optional stall statistics counter enabled by defining FWD_STALL_STATS_EN.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NSTAGE   = 2,
    parameter int LL_DEPTH = 4,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(NSTAGE + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid,
    input  logic [REG_AW-1:0]        ex_rs1,
    input  logic [REG_AW-1:0]        ex_rs2,
    input  logic [REG_AW-1:0]        ex_rd,
    input  logic                     ex_memread,
    input  logic [NSTAGE*REG_AW-1:0] stg_rd,
    input  logic [NSTAGE-1:0]        stg_wr,
    input  logic                     id_valid,
    input  logic [REG_AW-1:0]        id_rs1,
    input  logic [REG_AW-1:0]        id_rs2,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_ll,
    input  logic                     ll_issue,
    input  logic [REG_AW-1:0]        ll_rd,
    input  logic                     ll_done,
    input  logic [REG_AW-1:0]        ll_done_rd,
    output logic [SEL_W-1:0]         fwd_rs1_sel,
    output logic [SEL_W-1:0]         fwd_rs2_sel,
    output logic                     id_stall,
    output logic                     ex_bubble,
    output logic [3:0]               ll_cnt,
    output logic                     ll_full,
    output logic                     ll_err,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] sb_q, sb_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            full;
    logic            issue_ok, done_ok;
    logic            rs1_busy, rs2_busy;
    logic            hz_load_use, hz_sb, hz_ll;

    // Nearest stage wins: scan farthest to nearest so the last hit is the lowest k.
    function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [SEL_W-1:0] sel;
        sel = '0;
        if (ex_valid && (src != '0)) begin
            for (int k = NSTAGE; k >= 1; k--) begin
                if (stg_wr[k-1] && (stg_rd[(k-1)*REG_AW +: REG_AW] == src)) begin
                    sel = SEL_W'(k);
                end
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_rs1_sel = fwd_sel(ex_rs1);
        fwd_rs2_sel = fwd_sel(ex_rs2);
    end

    assign full     = (cnt_q == 4'(LL_DEPTH));
    assign issue_ok = ll_issue && (ll_rd != '0) && !full;
    assign done_ok  = ll_done && sb_q[ll_done_rd];

    always_comb begin
        sb_d = sb_q;
        if (done_ok) begin
            sb_d[ll_done_rd] = 1'b0;
        end
        if (issue_ok) begin
            sb_d[ll_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (issue_ok && !done_ok) begin
            cnt_d = cnt_q + 4'd1;
        end else if (done_ok && !issue_ok) begin
            cnt_d = cnt_q - 4'd1;
        end

        err_d = err_q || (ll_issue && full) || (ll_done && !sb_q[ll_done_rd]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // A register retiring this cycle is written through the register file, so it is not busy.
    assign rs1_busy = sb_q[id_rs1] && !(done_ok && (ll_done_rd == id_rs1));
    assign rs2_busy = sb_q[id_rs2] && !(done_ok && (ll_done_rd == id_rs2));

    assign hz_load_use = id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                         ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign hz_sb       = id_valid && (rs1_busy || rs2_busy);
    assign hz_ll       = id_valid && id_ll && (full || sb_q[id_rd]);

    assign id_stall  = hz_load_use || hz_sb || hz_ll;
    assign ex_bubble = id_stall;
    assign ll_cnt    = cnt_q;
    assign ll_full   = full;
    assign ll_err    = err_q;

`ifdef FWD_STALL_STATS_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (id_stall && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;

    localparam int REG_AW = 5;
    localparam int NSTAGE = 2;
    localparam int CNT_W  = 16;
    localparam int SEL_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     ex_valid;
    logic [REG_AW-1:0]        ex_rs1, ex_rs2, ex_rd;
    logic                     ex_memread;
    logic [NSTAGE*REG_AW-1:0] stg_rd;
    logic [NSTAGE-1:0]        stg_wr;
    logic                     id_valid;
    logic [REG_AW-1:0]        id_rs1, id_rs2, id_rd;
    logic                     id_ll;
    logic                     ll_issue;
    logic [REG_AW-1:0]        ll_rd;
    logic                     ll_done;
    logic [REG_AW-1:0]        ll_done_rd;
    logic [SEL_W-1:0]         fwd_rs1_sel, fwd_rs2_sel;
    logic                     id_stall, ex_bubble;
    logic [3:0]               ll_cnt;
    logic                     ll_full, ll_err;
    logic [CNT_W-1:0]         stall_cycles;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_AW(REG_AW), .NSTAGE(NSTAGE), .LL_DEPTH(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .stg_rd(stg_rd), .stg_wr(stg_wr),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_ll(id_ll), .ll_issue(ll_issue), .ll_rd(ll_rd),
        .ll_done(ll_done), .ll_done_rd(ll_done_rd),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .id_stall(id_stall), .ex_bubble(ex_bubble),
        .ll_cnt(ll_cnt), .ll_full(ll_full), .ll_err(ll_err),
        .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0;
        stg_rd = '0; stg_wr = '0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ll = 0;
        ll_issue = 0; ll_rd = 0; ll_done = 0; ll_done_rd = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic issue(input logic [REG_AW-1:0] rd);
        ll_issue = 1; ll_rd = rd;
        tick();
        ll_issue = 0; ll_rd = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #3;
        check("rst_cnt",   32'(ll_cnt), 0);
        check("rst_full",  32'(ll_full), 0);
        check("rst_err",   32'(ll_err), 0);
        check("rst_stall", 32'(id_stall), 0);
        check("rst_stats", 32'(stall_cycles), 0);
        do_reset();

        // Forwarding priority
        ex_valid = 1; stg_wr = 2'b11; stg_rd = {5'd5, 5'd5}; ex_rs1 = 5;
        #1 check("fwd_both_s1", 32'(fwd_rs1_sel), 1);
        stg_rd = {5'd5, 5'd6};
        #1 check("fwd_s2", 32'(fwd_rs1_sel), 2);
        ex_rs2 = 6;
        #1 check("fwd_rs2_s1", 32'(fwd_rs2_sel), 1);
        stg_wr = 2'b10;
        #1 check("fwd_rs2_nowr", 32'(fwd_rs2_sel), 0);
        ex_rs1 = 0; stg_rd = {5'd0, 5'd0}; stg_wr = 2'b11;
        #1 check("fwd_x0", 32'(fwd_rs1_sel), 0);
        ex_rs1 = 5; stg_rd = {5'd5, 5'd5}; ex_valid = 0;
        #1 check("fwd_exinv", 32'(fwd_rs1_sel), 0);
        clear_inputs();

        // Load-use
        ex_valid = 1; ex_memread = 1; ex_rd = 7; id_valid = 1; id_rs2 = 7;
        #1 check("lu_stall",  32'(id_stall), 1);
        check("lu_bubble", 32'(ex_bubble), 1);
        ex_rd = 0; id_rs2 = 0;
        #1 check("lu_x0", 32'(id_stall), 0);
        ex_rd = 7; id_rs2 = 7; ex_memread = 0;
        #1 check("lu_noload", 32'(id_stall), 0);
        clear_inputs();
        tick();

        // Scoreboard visibility and write-through on done
        id_valid = 1; id_rs1 = 9; ll_issue = 1; ll_rd = 9;
        #1 check("sb_t0", 32'(id_stall), 0);
        tick();
        ll_issue = 0; ll_rd = 0;
        check("sb_t1_stall", 32'(id_stall), 1);
        check("sb_t1_cnt",   32'(ll_cnt), 1);
        tick();
        check("sb_t2_stall", 32'(id_stall), 1);
        tick();
        ll_done = 1; ll_done_rd = 9;
        #1 check("sb_t3_wt", 32'(id_stall), 0);
        check("sb_t3_cnt", 32'(ll_cnt), 1);
        tick();
        ll_done = 0; ll_done_rd = 0;
        check("sb_t4_cnt",   32'(ll_cnt), 0);
        check("sb_t4_stall", 32'(id_stall), 0);
        check("sb_t4_err",   32'(ll_err), 0);

        // Fill to capacity
        id_rs1 = 0; id_ll = 1; id_rd = 20;
        for (int r = 1; r <= 4; r++) issue(REG_AW'(r));
        #1 check("full_cnt",   32'(ll_cnt), 4);
        check("full_flag",  32'(ll_full), 1);
        check("full_llstl", 32'(id_stall), 1);
        id_ll = 0;
        #1 check("full_nostl", 32'(id_stall), 0);
        issue(5'd5);
        check("full_drop_cnt", 32'(ll_cnt), 4);
        check("full_drop_err", 32'(ll_err), 1);
        id_rs1 = 5;
        #1 check("full_drop_sb", 32'(id_stall), 0);
        clear_inputs();

        // Simultaneous issue and done on different registers
        do_reset();
        check("rst2_err", 32'(ll_err), 0);
        issue(5'd1);
        ll_issue = 1; ll_rd = 3; ll_done = 1; ll_done_rd = 1;
        tick();
        clear_inputs();
        id_valid = 1;
        check("sim_cnt", 32'(ll_cnt), 1);
        check("sim_err", 32'(ll_err), 0);
        id_rs1 = 3;
        #1 check("sim_sb3", 32'(id_stall), 1);
        id_rs1 = 1;
        #1 check("sim_sb1", 32'(id_stall), 0);
        id_rs1 = 0; id_ll = 1; id_rd = 3;
        #1 check("waw_set", 32'(id_stall), 1);
        id_rd = 4;
        #1 check("waw_clr", 32'(id_stall), 0);
        id_ll = 0; id_rd = 0;
        ll_done = 1; ll_done_rd = 8;
        tick();
        ll_done = 0; ll_done_rd = 0;
        check("done_clr_err", 32'(ll_err), 1);
        check("done_clr_cnt", 32'(ll_cnt), 1);

        // Async reset mid-stall, checked before the next edge
        id_rs1 = 3;
        #1 check("pre_arst_stall", 32'(id_stall), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_stall", 32'(id_stall), 0);
        check("arst_cnt",   32'(ll_cnt), 0);
        check("arst_err",   32'(ll_err), 0);
        check("arst_stats", 32'(stall_cycles), 0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;

`ifdef FWD_STALL_STATS_EN
        ex_valid = 1; ex_memread = 1; ex_rd = 7; id_valid = 1; id_rs1 = 7;
        for (int i = 0; i < 10; i++) tick();
        clear_inputs();
        tick();
        check("stats_10", 32'(stall_cycles), 10);
        ex_valid = 1; ex_memread = 1; ex_rd = 7; id_valid = 1; id_rs1 = 7;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1 check("stats_arst", 32'(stall_cycles), 0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
`else
        ex_valid = 1; ex_memread = 1; ex_rd = 7; id_valid = 1; id_rs1 = 7;
        for (int i = 0; i < 10; i++) tick();
        check("stats_off", 32'(stall_cycles), 0);
        clear_inputs();
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
